down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Synchronous, loadable modulo-N down counter that is the counting-direction counterpart of the team's 3-bit up counter.
- Loads a start value, decrements on each enabled cycle, and flags terminal count with a one-cycle pulse when an enabled cycle occurs at zero.
- Then either reloads automatically or returns to idle.
- Used as a countdown timer or delay generator beside the up-counter datapath; it can feed the up counter's T enable.

Parameters:
- WIDTH, 3, bit width of the count and load value.
- MODULUS, 7, number of count states; legal count values are 0..MODULUS-1. Requires 2 <= MODULUS <= 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- en  input  1  count enable; decrement is qualified by en, like a T input.
- load  input  1  single-cycle request: capture load_val and start counting.
- load_val  input  WIDTH  start value and reload value.
- auto_reload  input  1  sampled with load; 1 = reload and continue after terminal count, 0 = stop after terminal count.
- count  output  WIDTH  current count value (registered).
- busy  output  1  1 while in RUN.
- tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (reset=1 at a clk edge):
  - count=0, busy=0, tc=0, state=IDLE.
  - Stored reload value = 0, stored auto_reload flag = 0.
  - Reset overrides every other input, including mid-count.
- Load value range:
  - Effective value v = load_val if load_val < MODULUS, else MODULUS-1.
  - Out-of-range values are clamped; count never leaves 0..MODULUS-1.
- States:
  - IDLE: count holds; busy=0; en is ignored.
  - RUN: busy=1.
- Transitions and per-edge actions (edge = rising edge of clk with reset=0):
  - load=1, any state: count<=v, stored reload<=v, stored flag<=auto_reload, state<=RUN, tc<=0. Load has priority over en and over terminal count in the same cycle.
  - RUN, load=0, en=0: everything holds; tc<=0.
  - RUN, load=0, en=1, count>0: count<=count-1; tc<=0.
  - RUN, load=0, en=1, count==0: tc<=1 for exactly the next cycle.
    - Stored flag=1: count<=stored reload; stay in RUN.
    - Stored flag=0: count stays 0; state<=IDLE, so busy=0 in the same cycle tc=1.
  - IDLE, load=0: count holds; tc<=0.
- Latency:
  - Loading v and holding en=1 produces tc high exactly v+1 cycles after the load edge.
  - With auto-reload, the tc period is v+1 enabled cycles.
- Boundary cases:
  - v=0: the first enabled cycle gives terminal count.
  - With auto-reload and v=0, tc is high every enabled cycle.
  - en toggling stretches the count without losing or duplicating states.
  - The counter never wraps from 0 to MODULUS-1 by decrement; it only moves away from 0 by reload or load.
- Arithmetic: count is unsigned, decremented by exactly 1; all outputs are registered, with no combinational paths from inputs to outputs.
- Reset mid-count or in the same cycle as tc or load: the reset values win, and tc is 0 on the following cycle.

Test Plan:
- Reset, then load=1, load_val=5, auto_reload=0, en=1 held -> count 5,4,3,2,1,0 on successive cycles; tc=1 for one cycle after the count=0 cycle (6 cycles after the load edge); busy falls with tc; count stays 0.
- load_val=3, auto_reload=1, en=1 for 12 cycles -> count 3,2,1,0,3,2,1,0,...; tc pulses every 4 cycles; busy stays 1.
- load_val=7 with MODULUS=7 -> count loads 6 (clamped), never exceeds 6; tc 7 cycles after load.
- load_val=4, en pattern 1,0,1,0,... -> count steps 4,4,3,3,2,... (holds on en=0 cycles); tc after the fifth enabled cycle.
- Reload during RUN: load_val=2 issued at count=1 while en=1 -> count=2 next cycle (load beats decrement), tc=0; count resumes 1,0, then tc.
- reset=1 asserted at count=3 in auto-reload mode, including in the same cycle as load=1 -> next cycle count=0, busy=0, tc=0; en alone then leaves count at 0.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable modulo-MODULUS down counter / countdown timer with a registered
// one-cycle terminal-count pulse and optional automatic reload.
module down_counter_timer #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             auto_q;
  logic             tc_q;
  logic [WIDTH-1:0] load_v;

  assign load_v = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else if (load) begin
      state_q  <= RUN;
      count_q  <= load_v;
      reload_q <= load_v;
      auto_q   <= auto_reload;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q != '0) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              // Terminal count: never wrap by decrement, only reload or stop.
              tc_q <= 1'b1;
              if (auto_q) count_q <= reload_q;
              else        state_q <= IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: a behavioural model pushes the
// expected outputs per cycle into a scoreboard queue, popped after each edge.
module tb_down_counter_timer;

  localparam int WIDTH   = 3;
  localparam int MODULUS = 7;

  logic             clk = 1'b0;
  logic             reset, en, load, auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy, tc;

  down_counter_timer #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .count      (count),
    .busy       (busy),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_count = 0, m_reload = 0;
  bit m_busy = 0, m_tc = 0, m_auto = 0;

  // Last observed tc, used for latency measurement
  logic obs_tc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit l, input int v, input bit ar, input bit e);
    int vv;
    if (r) begin
      m_count = 0; m_reload = 0; m_auto = 0; m_busy = 0; m_tc = 0;
    end else if (l) begin
      vv = (v < MODULUS) ? v : MODULUS - 1;
      m_count = vv; m_reload = vv; m_auto = ar; m_busy = 1; m_tc = 0;
    end else if (m_busy && e) begin
      if (m_count > 0) begin
        m_count--; m_tc = 0;
      end else begin
        m_tc = 1;
        if (m_auto) m_count = m_reload;
        else        m_busy = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // Drive one cycle of stimulus (called on the falling edge), then check after the rising edge.
  task automatic cycle(input bit r, input bit l, input int v, input bit ar, input bit e);
    exp_t x;
    reset = r; load = l; load_val = WIDTH'(v); auto_reload = ar; en = e;
    model_step(r, l, v, ar, e);
    sb_q.push_back('{count: WIDTH'(m_count), busy: m_busy, tc: m_tc});
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("count", int'(count), int'(x.count));
    check("busy",  int'(busy),  int'(x.busy));
    check("tc",    int'(tc),    int'(x.tc));
    obs_tc = tc;
    @(negedge clk);
  endtask

  // Run n enabled cycles and return the first cycle index (1-based) with tc high, or -1.
  task automatic run_en(input int n, output int first_tc);
    first_tc = -1;
    for (int k = 1; k <= n; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (obs_tc === 1'b1 && first_tc < 0) first_tc = k;
    end
  endtask

  initial begin
    int ftc;
    reset = 1; load = 0; load_val = '0; auto_reload = 0; en = 0;
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);

    // Idle ignores en
    cycle(0, 0, 0, 0, 1);

    // Single shot from 5: tc six cycles after load, busy falls with tc
    cycle(0, 1, 5, 0, 1);
    run_en(9, ftc);
    check("latency_v5", ftc, 6);

    // Auto-reload from 3: tc every 4 cycles, busy stays high
    cycle(0, 1, 3, 1, 1);
    run_en(12, ftc);
    check("latency_v3_ar", ftc, 4);

    // Out-of-range load clamps to MODULUS-1
    cycle(0, 1, 7, 0, 1);
    check("clamp_count", int'(count), MODULUS - 1);
    run_en(9, ftc);
    check("latency_clamp", ftc, 7);

    // en toggling stretches the count: tc after the fifth enabled cycle
    cycle(0, 1, 4, 0, 1);
    for (int k = 0; k < 12; k++) cycle(0, 0, 0, 0, (k % 2) == 0);

    // Reload during RUN beats decrement
    cycle(0, 1, 5, 0, 1);
    run_en(4, ftc);
    check("pre_reload_count", int'(count), 1);
    cycle(0, 1, 2, 0, 1);
    run_en(4, ftc);
    check("latency_after_reload", ftc, 3);

    // v=0 with auto-reload: tc every enabled cycle
    cycle(0, 1, 0, 1, 1);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Reset mid-count in auto-reload mode, then reset together with load
    cycle(0, 1, 5, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 3, 1, 1);
    cycle(1, 1, 4, 1, 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1);

    // Reset in the same cycle as terminal count
    cycle(0, 1, 0, 1, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    if (sb_q.size() != 0) check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
